// File: rtl/linebuf_pingpong_if.sv
// Bus bundle for linebuf_pingpong: write port, display read port, bank status.
// Collision outputs exist only when LINEBUF_COLLISION_EN is defined.
interface linebuf_pingpong_if #(
    parameter int AW = 10,
    parameter int DW = 11
);
    logic          swap;
    logic          wr_en;
    logic [AW-1:0] wr_adr;
    logic [DW-1:0] wr_dat;
    logic          rd_en;
    logic [AW-1:0] rd_adr;
    logic [DW-1:0] rd_dat;
    logic          rd_vld;
    logic          wbank;
`ifdef LINEBUF_COLLISION_EN
    logic          col_hit;
    logic [AW-1:0] col_adr;

    modport master (
        output swap, wr_en, wr_adr, wr_dat, rd_en, rd_adr,
        input  rd_dat, rd_vld, wbank, col_hit, col_adr
    );
    modport slave (
        input  swap, wr_en, wr_adr, wr_dat, rd_en, rd_adr,
        output rd_dat, rd_vld, wbank, col_hit, col_adr
    );
`else
    modport master (
        output swap, wr_en, wr_adr, wr_dat, rd_en, rd_adr,
        input  rd_dat, rd_vld, wbank
    );
    modport slave (
        input  swap, wr_en, wr_adr, wr_dat, rd_en, rd_adr,
        output rd_dat, rd_vld, wbank
    );
`endif
endinterface

// File: rtl/linebuf_pingpong.sv
// Double-banked scanline buffer: transparent/priority-aware composition into one bank,
// clear-on-read display from the other. Optional collision detect: LINEBUF_COLLISION_EN.
module linebuf_pingpong #(
    parameter int AW         = 10,
    parameter int DW         = 11,
    parameter int TW         = 4,
    parameter int FIRST_WINS = 1,
    parameter int CLR_ON_RD  = 1
) (
    input logic               clk,
    input logic               reset,
    linebuf_pingpong_if.slave bus
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [0:1][0:DEPTH-1];

    logic          wbank_q, wbank_d;
    logic          s1Vld_q, s1Vld_d;
    logic          s1Bank_q, s1Bank_d;
    logic [AW-1:0] s1Adr_q, s1Adr_d;
    logic [DW-1:0] s1Dat_q, s1Dat_d;
    logic [DW-1:0] s1Old_q, s1Old_d;
    logic [DW-1:0] rdDat_q, rdDat_d;
    logic          rdVld_q, rdVld_d;

    logic          newOpaque;
    logic          oldOpaque;
    logic          commit;
    logic          fwd;
    logic          rdBank;
    logic          clrEn;

    // S1 sees the pre-existing word (RAM or forwarded) and decides whether to commit.
    always_comb begin
        newOpaque = |s1Dat_q[TW-1:0];
        oldOpaque = |s1Old_q[TW-1:0];
        commit    = s1Vld_q && newOpaque && ((FIRST_WINS == 0) || !oldOpaque);
        fwd       = commit && (s1Bank_q == wbank_q) && (s1Adr_q == bus.wr_adr);
        rdBank    = ~wbank_q;
        clrEn     = (CLR_ON_RD != 0) && bus.rd_en;

        wbank_d   = wbank_q ^ bus.swap;
        s1Vld_d   = bus.wr_en;
        s1Bank_d  = wbank_q;
        s1Adr_d   = bus.wr_adr;
        s1Dat_d   = bus.wr_dat;
        s1Old_d   = fwd ? s1Dat_q : mem[wbank_q][bus.wr_adr];
        rdVld_d   = bus.rd_en;
        rdDat_d   = bus.rd_en ? mem[rdBank][bus.rd_adr] : rdDat_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wbank_q  <= 1'b0;
            s1Vld_q  <= 1'b0;
            s1Bank_q <= 1'b0;
            s1Adr_q  <= '0;
            s1Dat_q  <= '0;
            s1Old_q  <= '0;
            rdDat_q  <= '0;
            rdVld_q  <= 1'b0;
        end else begin
            wbank_q  <= wbank_d;
            s1Vld_q  <= s1Vld_d;
            s1Bank_q <= s1Bank_d;
            s1Adr_q  <= s1Adr_d;
            s1Dat_q  <= s1Dat_d;
            s1Old_q  <= s1Old_d;
            rdDat_q  <= rdDat_d;
            rdVld_q  <= rdVld_d;
        end
    end

    // The clear is written after the commit so it wins when a late commit lands in the read bank.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (commit) begin
                mem[s1Bank_q][s1Adr_q] <= s1Dat_q;
            end
            if (clrEn) begin
                mem[rdBank][bus.rd_adr] <= '0;
            end
        end
    end

    assign bus.rd_dat = rdDat_q;
    assign bus.rd_vld = rdVld_q;
    assign bus.wbank  = wbank_q;

`ifdef LINEBUF_COLLISION_EN
    logic          colHit;
    logic [AW-1:0] colAdr_q, colAdr_d;

    // Collision ignores the priority rule: any opaque-over-opaque write in S1 counts.
    always_comb begin
        colHit   = !reset && s1Vld_q && newOpaque && oldOpaque;
        colAdr_d = colHit ? s1Adr_q : colAdr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            colAdr_q <= '0;
        end else begin
            colAdr_q <= colAdr_d;
        end
    end

    assign bus.col_hit = colHit;
    assign bus.col_adr = colAdr_d;
`endif
endmodule
